// File: rtl/dma_ch_arb.sv
// Round-robin DMA channel arbiter with a three-state grant FSM (IDLE/START/BUSY).
// Define DMA_ARB_PRIO_EN to restrict eligibility to the highest-priority requesters.
module dma_ch_arb #(
    parameter  int CH_NUM = 15,
    parameter  int PRI_W  = 3,
    localparam int ID_W   = $clog2(CH_NUM)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [CH_NUM-1:0]       req_i,
    input  logic [CH_NUM*PRI_W-1:0] pri_i,
    input  logic                    pause_i,
    input  logic                    done_i,
    output logic [CH_NUM-1:0]       gnt_o,
    output logic [ID_W-1:0]         gnt_id_o,
    output logic                    gnt_vld_o,
    output logic                    start_o
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY
    } state_t;

    state_t            state, state_nx;
    logic [ID_W-1:0]   ptr, ptr_nx;
    logic [CH_NUM-1:0] gnt_nx;
    logic [ID_W-1:0]   gnt_id_nx;
    logic              gnt_vld_nx;
    logic              start_nx;

    logic [CH_NUM-1:0] elig;
    logic [ID_W-1:0]   win_id;
    logic              win_found;

`ifdef DMA_ARB_PRIO_EN
    logic [PRI_W-1:0] max_pri;

    // Only requesters sharing the highest requested priority may compete.
    always_comb begin
        max_pri = '0;
        elig    = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (req_i[i] && (pri_i[i*PRI_W +: PRI_W] > max_pri))
                max_pri = pri_i[i*PRI_W +: PRI_W];
        end
        for (int i = 0; i < CH_NUM; i++)
            elig[i] = req_i[i] && (pri_i[i*PRI_W +: PRI_W] == max_pri);
    end
`else
    logic unused_pri;

    assign unused_pri = ^pri_i;

    always_comb elig = req_i;
`endif

    // Scan ptr, ptr+1, ... modulo CH_NUM and take the first eligible channel.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] cand;
        win_id    = '0;
        win_found = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(CH_NUM))
                sum = sum - (ID_W+1)'(CH_NUM);
            cand = sum[ID_W-1:0];
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        gnt_nx     = gnt_o;
        gnt_id_nx  = gnt_id_o;
        gnt_vld_nx = gnt_vld_o;
        start_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_nx     = '0;
                gnt_id_nx  = '0;
                gnt_vld_nx = 1'b0;
                if (win_found && !pause_i) begin
                    state_nx         = START;
                    gnt_nx[win_id]   = 1'b1;
                    gnt_id_nx        = win_id;
                    gnt_vld_nx       = 1'b1;
                    start_nx         = 1'b1;
                end
            end
            START: begin
                state_nx = BUSY;
            end
            BUSY: begin
                if (done_i) begin
                    state_nx   = IDLE;
                    gnt_nx     = '0;
                    gnt_id_nx  = '0;
                    gnt_vld_nx = 1'b0;
                    ptr_nx     = (gnt_id_o == ID_W'(CH_NUM-1)) ? '0 : gnt_id_o + ID_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_o     <= '0;
            gnt_id_o  <= '0;
            gnt_vld_o <= 1'b0;
            start_o   <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            gnt_o     <= gnt_nx;
            gnt_id_o  <= gnt_id_nx;
            gnt_vld_o <= gnt_vld_nx;
            start_o   <= start_nx;
        end
    end

endmodule

// File: doc/dma_ch_arb.md
DMA_CH_ARB -- requirements
Module: dma_ch_arb

Interface
REQ-001 SHALL have parameter CH_NUM, default 15: number of DMA channels, legal range 2..31.
REQ-002 SHALL have parameter PRI_W, default 3: per-channel priority width.
REQ-003 SHALL have localparam ID_W = $clog2(CH_NUM).
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 req_i  input  CH_NUM  per-channel transfer request; bit i belongs to channel i.
REQ-007 pri_i  input  CH_NUM*PRI_W  packed priorities; channel i uses bits [i*PRI_W +: PRI_W]; larger value means higher priority.
REQ-008 pause_i  input  1  global pause; blocks new grants only.
REQ-009 done_i  input  1  single-cycle pulse from the transfer engine: the granted channel's burst has finished.
REQ-010 gnt_o  output  CH_NUM  one-hot grant, registered.
REQ-011 gnt_id_o  output  ID_W  binary index of the granted channel, registered.
REQ-012 gnt_vld_o  output  1  high while any grant is held.
REQ-013 start_o  output  1  one-cycle pulse in the first cycle of each grant.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, START, BUSY.
REQ-015 IDLE: if (|req_i) && !pause_i, SHALL latch winner into gnt_o/gnt_id_o and go to START; otherwise SHALL stay in IDLE with gnt_o=0.
REQ-016 START: start_o=1, gnt_vld_o=1; SHALL go to BUSY next cycle unconditionally.
REQ-017 BUSY: grant held; on done_i SHALL clear gnt_o, gnt_id_o, gnt_vld_o at the next edge, advance pointer, and return to IDLE.
REQ-018 Latency: a request seen in IDLE at edge n SHALL give gnt_o and start_o valid in the cycle after edge n; consecutive grants SHALL be separated by at least one IDLE cycle.
REQ-019 Round-robin pointer ptr (ID_W bits) SHALL, on done_i, load gnt_id_o+1, wrapping CH_NUM-1 -> 0.
REQ-020 Winner search SHALL scan channels ptr, ptr+1, ... modulo CH_NUM and pick the first requester, subject to REQ-030.
REQ-021 Grant SHALL be held until done_i even if req_i of the granted channel drops; abort is the engine's job.
REQ-022 done_i in START SHALL be ignored; done_i in IDLE SHALL be ignored and SHALL NOT move ptr.
REQ-023 pause_i SHALL NOT affect a grant already in START/BUSY; it SHALL only block the IDLE->START transition.
REQ-024 gnt_o SHALL always be one-hot or zero, and gnt_o[gnt_id_o] SHALL equal gnt_vld_o.

Reset
REQ-025 rst_i high at a rising edge SHALL force state=IDLE, ptr=0, gnt_o=0, gnt_id_o=0, gnt_vld_o=0, start_o=0.
REQ-026 Reset asserted mid-grant (START or BUSY) SHALL drop the grant at that edge with no done_i required.
REQ-027 The first arbitration after reset release SHALL start the search at channel 0.

Configuration
REQ-028 SHALL support macro DMA_ARB_PRIO_EN.
REQ-029 Without DMA_ARB_PRIO_EN: pri_i SHALL be ignored and selection SHALL be pure round-robin per REQ-020.
REQ-030 With DMA_ARB_PRIO_EN: only requesters whose priority equals the maximum priority among current requesters SHALL be eligible; ties SHALL be broken by the REQ-020 scan from ptr.

Verification (bench CH_NUM=4, PRI_W=3)
REQ-031 Reset, req_i=4'b0100 -> gnt_o=4'b0100, gnt_id_o=2 and start_o=1 one cycle after the request edge; after done_i -> gnt_o=0 and ptr=3.
REQ-032 req_i=4'b1111 held, done_i four cumulative times, priority build -> grants in order 0,1,2,3, then wrap to 0, with one IDLE cycle between grants.
REQ-033 Grant on channel 1, then req_i[1] drops and pause_i=1 -> grant held until done_i; after done_i no new grant while pause_i=1; pause_i=0 -> next grant issued.
REQ-034 DMA_ARB_PRIO_EN, pri={ch3:5, ch2:1, ch1:5, ch0:7}, req_i=4'b1110 -> grant ch1, then ch3, then ch1; ch2 never granted while ch1 and ch3 keep requesting.
REQ-035 rst_i pulsed while in BUSY on channel 2 -> gnt_o=0 at that edge; next request 4'b1111 -> ch0 granted.
REQ-036 done_i pulsed in IDLE and in START -> no state or pointer change; the one-hot check on gnt_o SHALL hold every cycle.
